// File: rtl/counter_monitor_pkg.sv
// Shared types, mode/terminal constants and Gray helpers for the counter sequence monitor.
package counter_monitor_pkg;

   typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, FAULT} state_t;

   localparam logic       MODE_BIN  = 1'b0;
   localparam logic       MODE_GRAY = 1'b1;
   localparam logic [2:0] TERM_BIN  = 3'b111;
   localparam logic [2:0] TERM_GRAY = 3'b100;

   function automatic logic [2:0] gray2bin(input logic [2:0] g);
      logic [2:0] b;
      b[2] = g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   function automatic logic [2:0] next_gray(input logic [2:0] g);
      logic [2:0] b;
      b = gray2bin(g) + 3'd1;
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/counter_sequence_monitor_seg7_decoder.sv
// Registered binary-to-7-segment decode (bit 0 = a ... bit 6 = g, active high).
module seg7_decoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] bin,
   output logic [6:0] seg
);

   logic [6:0] seg_d;

   always_comb begin
      seg_d = 7'h00;
      case (bin)
         3'd0:    seg_d = 7'h3F;
         3'd1:    seg_d = 7'h06;
         3'd2:    seg_d = 7'h5B;
         3'd3:    seg_d = 7'h4F;
         3'd4:    seg_d = 7'h66;
         3'd5:    seg_d = 7'h6D;
         3'd6:    seg_d = 7'h7D;
         default: seg_d = 7'h07;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seg <= 7'h3F;
      else        seg <= seg_d;
   end

endmodule

// File: rtl/counter_sequence_monitor.sv
// Checks an upstream binary/Gray counter for legal stepping and terminal-flag agreement.
// Optional 7-segment output is built only when SEVEN_SEG_EN is defined.
module counter_sequence_monitor
   import counter_monitor_pkg::*;
(
   input  logic       Clock,
   input  logic       nReset,
   input  logic       Control,
   input  logic [2:0] Counter,
   input  logic       Flag,
   output logic [2:0] Value,
   output logic [6:0] Segments,
   output logic       Error,
   output logic [7:0] ErrorCount,
   output logic [7:0] WrapCount,
   output logic       Locked
);

   state_t     state, next_state;
   logic [2:0] s_cnt, p_cnt;
   logic       s_ctl, p_ctl, s_flag, s_valid;
   logic       run_one, run_one_next;
   logic       err_ev, wrap_ev;
   logic [2:0] value_d, term_val;
   logic       legal_step, flag_bad, mode_chg, stall, is_wrap, viol;

   assign value_d = (Control == MODE_GRAY) ? gray2bin(Counter) : Counter;

   // Input sample stage; s_valid marks that a post-reset sample exists.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         s_cnt   <= '0;
         s_ctl   <= 1'b0;
         s_flag  <= 1'b0;
         s_valid <= 1'b0;
         Value   <= '0;
      end else begin
         s_cnt   <= Counter;
         s_ctl   <= Control;
         s_flag  <= Flag;
         s_valid <= 1'b1;
         Value   <= value_d;
      end
   end

   assign term_val   = (s_ctl == MODE_GRAY) ? TERM_GRAY : TERM_BIN;
   assign legal_step = (s_ctl == MODE_GRAY) ? (s_cnt == next_gray(p_cnt))
                                            : (s_cnt == p_cnt + 3'd1);
   assign flag_bad   = s_flag != (s_cnt == term_val);
   assign mode_chg   = s_ctl != p_ctl;
   assign stall      = s_cnt == p_cnt;
   assign is_wrap    = (p_cnt == term_val) && (s_cnt == 3'b000);
   assign viol       = !legal_step || flag_bad;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else         state <= next_state;
   end

   // Priority: first sample, then mode change, then FAULT exit, then stall.
   always_comb begin
      next_state   = state;
      run_one_next = run_one;
      err_ev       = 1'b0;
      wrap_ev      = 1'b0;
      if (s_valid) begin
         if (state == IDLE) begin
            next_state   = ACQUIRE;
            run_one_next = 1'b0;
            err_ev       = flag_bad;
         end else if (mode_chg || state == FAULT) begin
            next_state   = ACQUIRE;
            run_one_next = 1'b0;
         end else if (!stall) begin
            case (state)
               ACQUIRE: begin
                  if (viol) begin
                     err_ev       = 1'b1;
                     run_one_next = 1'b0;
                  end else if (run_one) begin
                     next_state   = TRACK;
                     run_one_next = 1'b0;
                  end else begin
                     run_one_next = 1'b1;
                  end
               end
               TRACK: begin
                  if (viol) begin
                     err_ev     = 1'b1;
                     next_state = FAULT;
                  end else begin
                     wrap_ev = is_wrap;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      Locked = (state == TRACK);
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         p_cnt      <= '0;
         p_ctl      <= 1'b0;
         run_one    <= 1'b0;
         Error      <= 1'b0;
         ErrorCount <= '0;
         WrapCount  <= '0;
      end else begin
         if (s_valid) begin
            p_cnt <= s_cnt;
            p_ctl <= s_ctl;
         end
         run_one <= run_one_next;
         Error   <= err_ev;
         if (err_ev && ErrorCount != '1) ErrorCount <= ErrorCount + 8'd1;
         if (wrap_ev) WrapCount <= WrapCount + 8'd1;
      end
   end

`ifdef SEVEN_SEG_EN
   // Decoder registers value_d so Segments stays aligned with Value.
   seg7_decoder u_seg7 (
      .clk   (Clock),
      .rst_n (nReset),
      .bin   (value_d),
      .seg   (Segments)
   );
`else
   assign Segments = '0;
`endif

endmodule

// File: tb/tb_counter_sequence_monitor.sv
// Table-driven bench for counter_sequence_monitor plus hand sequences for saturation and reset.
module tb_counter_sequence_monitor;
   import counter_monitor_pkg::*;

   logic       Clock = 1'b0;
   logic       nReset, Control, Flag;
   logic [2:0] Counter;
   logic [2:0] Value;
   logic [6:0] Segments;
   logic       Error, Locked;
   logic [7:0] ErrorCount, WrapCount;

   int tests = 0;
   int failed = 0;

   counter_sequence_monitor dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .Control    (Control),
      .Counter    (Counter),
      .Flag       (Flag),
      .Value      (Value),
      .Segments   (Segments),
      .Error      (Error),
      .ErrorCount (ErrorCount),
      .WrapCount  (WrapCount),
      .Locked     (Locked)
   );

   always #5 Clock = ~Clock;

   // Expected results describe the evaluation of that sample.
   typedef struct {
      logic       ctl;
      logic [2:0] cnt;
      logic       flg;
      logic [2:0] val;
      logic       err;
      logic       lck;
      int         ecnt;
      int         wcnt;
   } vec_t;

   vec_t tv[64];
   int   nv = 0;

   task automatic add(input logic c, input logic [2:0] n, input logic f, input logic [2:0] v,
                      input logic e, input logic l, input int ec, input int wc);
      tv[nv].ctl = c; tv[nv].cnt = n; tv[nv].flg = f; tv[nv].val = v;
      tv[nv].err = e; tv[nv].lck = l; tv[nv].ecnt = ec; tv[nv].wcnt = wc;
      nv++;
   endtask

   function automatic logic [6:0] seg_of(input logic [2:0] v);
      logic [6:0] s;
      s = 7'h00;
`ifdef SEVEN_SEG_EN
      case (v)
         3'd0: s = 7'h3F; 3'd1: s = 7'h06; 3'd2: s = 7'h5B; 3'd3: s = 7'h4F;
         3'd4: s = 7'h66; 3'd5: s = 7'h6D; 3'd6: s = 7'h7D; default: s = 7'h07;
      endcase
`endif
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_eval(input string tag, input vec_t p);
      check({tag, " Error"}, 32'(Error), 32'(p.err));
      check({tag, " Locked"}, 32'(Locked), 32'(p.lck));
      check({tag, " ErrorCount"}, 32'(ErrorCount), p.ecnt);
      check({tag, " WrapCount"}, 32'(WrapCount), p.wcnt);
   endtask

   // Called at a negedge with reset released; ends at a negedge.
   task automatic run_range(input string nm, input int lo, input int hi);
      vec_t prev;
      prev = '{ctl: 1'b0, cnt: 3'd0, flg: 1'b0, val: 3'd0, err: 1'b0, lck: 1'b0, ecnt: 0, wcnt: 0};
      for (int i = lo; i < hi; i++) begin
         Control = tv[i].ctl; Counter = tv[i].cnt; Flag = tv[i].flg;
         @(posedge Clock); #1;
         check($sformatf("%s[%0d] Value", nm, i - lo), 32'(Value), 32'(tv[i].val));
         check($sformatf("%s[%0d] Segments", nm, i - lo), 32'(Segments), 32'(seg_of(tv[i].val)));
         check_eval($sformatf("%s[%0d]", nm, i - lo), prev);
         prev = tv[i];
         @(negedge Clock);
      end
      @(posedge Clock); #1;
      check_eval($sformatf("%s drain", nm), prev);
      @(negedge Clock);
   endtask

   logic [2:0] gseq[8];
   int a_end;

   initial begin
      gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010;
      gseq[4] = 3'b110; gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100;

      // Binary count, stall, wrap, skip, flag mismatch, mode switch, violation at wrap.
      add(0,0,0, 0,0,0,0,0); add(0,1,0, 1,0,0,0,0); add(0,2,0, 2,0,1,0,0);
      add(0,3,0, 3,0,1,0,0); add(0,3,0, 3,0,1,0,0); add(0,4,0, 4,0,1,0,0);
      add(0,5,0, 5,0,1,0,0); add(0,6,0, 6,0,1,0,0); add(0,7,1, 7,0,1,0,0);
      add(0,0,0, 0,0,1,0,1); add(0,1,0, 1,0,1,0,1); add(0,2,0, 2,0,1,0,1);
      add(0,3,0, 3,0,1,0,1); add(0,5,0, 5,1,0,1,1); add(0,6,0, 6,0,0,1,1);
      add(0,7,1, 7,0,0,1,1); add(0,0,0, 0,0,1,1,1); add(0,1,0, 1,0,1,1,1);
      add(0,2,0, 2,0,1,1,1); add(0,3,0, 3,0,1,1,1); add(0,4,0, 4,0,1,1,1);
      add(0,5,0, 5,0,1,1,1); add(0,6,1, 6,1,0,2,1); add(0,7,1, 7,0,0,2,1);
      add(0,0,0, 0,0,0,2,1); add(0,1,0, 1,0,1,2,1);
      add(1,3'b011,0, 2,0,0,2,1); add(1,3'b010,0, 3,0,0,2,1); add(1,3'b110,0, 4,0,1,2,1);
      add(1,3'b111,0, 5,0,1,2,1); add(1,3'b101,0, 6,0,1,2,1); add(1,3'b100,1, 7,0,1,2,1);
      add(1,3'b000,1, 0,1,0,3,1);
      a_end = nv;
      // Gray sequence twice from reset, ending on the second wrap.
      for (int k = 0; k < 17; k++)
         add(1, gseq[k % 8], (k % 8) == 7, 3'(k % 8), 0, k >= 2, 0, (k >= 16) ? 2 : (k >= 8) ? 1 : 0);

      nReset = 1'b0; Control = 1'b0; Counter = 3'd0; Flag = 1'b0;
      #12;
      check("reset Value", 32'(Value), 0);
      check("reset Segments", 32'(Segments), 32'(seg_of(3'd0)));
      check("reset Error", 32'(Error), 0);
      check("reset Locked", 32'(Locked), 0);
      check("reset ErrorCount", 32'(ErrorCount), 0);
      check("reset WrapCount", 32'(WrapCount), 0);
      check("reset state", 32'(dut.state), 32'(IDLE));
      @(negedge Clock); nReset = 1'b1;
      run_range("bin", 0, a_end);

      nReset = 1'b0;
      @(negedge Clock); nReset = 1'b1;
      run_range("gray", a_end, nv);

      // Stride-2 binary stream after a mode switch: every later sample violates.
      for (int i = 0; i < 310; i++) begin
         Control = 1'b0; Counter = 3'((2 * i) % 8); Flag = 1'b0;
         @(posedge Clock); #1;
         if (i == 1) check("sat modeswitch ErrorCount", 32'(ErrorCount), 0);
         if (i == 100) begin
            check("sat mid ErrorCount", 32'(ErrorCount), 99);
            check("sat mid Error", 32'(Error), 1);
            check("sat mid Locked", 32'(Locked), 0);
         end
         @(negedge Clock);
      end
      check("sat ErrorCount", 32'(ErrorCount), 255);
      check("sat WrapCount", 32'(WrapCount), 2);

      Counter = 3'd1;
      @(posedge Clock); #2;
      nReset = 1'b0;
      #1;
      check("midreset Value", 32'(Value), 0);
      check("midreset Segments", 32'(Segments), 32'(seg_of(3'd0)));
      check("midreset Error", 32'(Error), 0);
      check("midreset ErrorCount", 32'(ErrorCount), 0);
      check("midreset WrapCount", 32'(WrapCount), 0);
      check("midreset Locked", 32'(Locked), 0);
      check("midreset state", 32'(dut.state), 32'(IDLE));
      @(negedge Clock); nReset = 1'b1; Counter = 3'd3;
      @(posedge Clock); #1;
      check("post-reset Value", 32'(Value), 3);
      check("post-reset state", 32'(dut.state), 32'(IDLE));
      @(negedge Clock); Counter = 3'd4;
      @(posedge Clock); #1;
      check("reacquire state", 32'(dut.state), 32'(ACQUIRE));
      check("reacquire ErrorCount", 32'(ErrorCount), 0);
      check("reacquire Error", 32'(Error), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/counter_sequence_monitor.md
COUNTER_SEQUENCE_MONITOR -- requirements
Module: counter_sequence_monitor

Interface
REQ-001 The block SHALL have the port Clock, input, 1 bit: the single system clock, with all state updating on the rising edge.
REQ-002 The block SHALL have the port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port Control, input, 1 bit: upstream mode, 0 = binary/BCD count 0..7, 1 = Gray sequence 000,001,011,010,110,111,101,100.
REQ-004 The block SHALL have the port Counter, input, 3 bits: upstream counter value, sampled every cycle.
REQ-005 The block SHALL have the port Flag, input, 1 bit: upstream terminal-count flag; it is valid high only while Counter holds the terminal value for the current mode (7 binary, 100 Gray).
REQ-006 The block SHALL have the port Value, output, 3 bits: the sampled Counter converted to binary, registered.
REQ-007 The block SHALL have the port Segments, output, 7 bits: active-high segments a..g for Value.
REQ-008 The block SHALL have the port Error, output, 1 bit: one-cycle pulse per detected violation.
REQ-009 The block SHALL have the port ErrorCount, output, 8 bits: saturating count of violations.
REQ-010 The block SHALL have the port WrapCount, output, 8 bits: count of correct terminal-to-zero transitions, wrapping modulo 256.
REQ-011 The block SHALL have the port Locked, output, 1 bit: high while in TRACK.

Function
REQ-012 The block SHALL register Counter, Control and Flag each cycle; all outputs SHALL derive from the registered sample, giving 1-cycle latency from input to Value and Segments, and 2-cycle latency from input to Error.
REQ-013 The block SHALL, in binary mode, require Counter to change by +1 mod 8 per cycle; in Gray mode, it SHALL require Counter to advance to the next Gray code, wrapping 100->000.
REQ-014 The block SHALL treat Counter equal to the previous sample as a stall: no error, and no change to state or counters.
REQ-015 The block SHALL flag a violation when the transition is illegal for the mode, or when Flag disagrees with the terminal-value test on the same sample.
REQ-016 The block SHALL use the FSM states IDLE, ACQUIRE, TRACK and FAULT.
REQ-017 The block SHALL move from IDLE to ACQUIRE on the first sample after reset; the Flag check applies to that sample, but the transition check does not.
REQ-018 The block SHALL move from ACQUIRE to TRACK after 2 consecutive legal transitions; a violation seen in ACQUIRE SHALL count as an error and restart the run count.
REQ-019 The block SHALL move from TRACK to FAULT on a violation, and from FAULT to ACQUIRE unconditionally on the next cycle.
REQ-020 The block SHALL, when Control differs from the previous sample, enter ACQUIRE without counting an error; this takes priority over every other transition, in any state.
REQ-021 The block SHALL increment WrapCount only in TRACK, on a legal terminal-to-000 transition.
REQ-022 The block SHALL hold ErrorCount at 255 once it saturates.
REQ-023 The block SHALL count a violation that coincides with a wrap as an error only, with no WrapCount increment.

Reset
REQ-024 The block SHALL, while nReset is low, force the state to IDLE and set Value, Error, ErrorCount, WrapCount and Locked to 0; Segments SHALL show the pattern for 0 (7'h3F), or 0 when the macro is undefined.
REQ-025 The block SHALL apply nReset asserted mid-sequence immediately and discard all history; the first sample after release SHALL re-enter ACQUIRE.

Configuration
REQ-026 The block SHALL, with SEVEN_SEG_EN defined, drive Segments from a registered binary-to-7-segment decode of Value.
REQ-027 The block SHALL, with SEVEN_SEG_EN undefined, tie Segments to 0 and instantiate no decoder logic; all other behaviour SHALL be unchanged.

Structure
REQ-028 The package counter_monitor_pkg SHALL hold the state enum, the mode constants (MODE_BIN=0, MODE_GRAY=1), the terminal values (3'b111, 3'b100), the next-Gray function and the Gray-to-binary function.
REQ-029 The segment decode SHALL be a single sub-module, seg7_decoder, instantiated only under SEVEN_SEG_EN.

Verification
REQ-030 The bench SHALL check binary mode: Counter 0..7,0 with Flag high only at 7 -> Locked high from the third sample, WrapCount=1, ErrorCount=0.
REQ-031 The bench SHALL check Gray mode: the full Gray sequence twice with correct Flag -> Value steps 0..7, WrapCount=2, Error never high.
REQ-032 The bench SHALL check skip detection: in binary TRACK, drive 3 then 5 -> one Error pulse, ErrorCount=1, FAULT then ACQUIRE, Locked low for at least 3 cycles.
REQ-033 The bench SHALL check flag mismatch: in binary mode, drive Counter=6 with Flag=1 -> Error pulse, with no transition error counted.
REQ-034 The bench SHALL check a mode switch: toggle Control mid-count -> ACQUIRE, ErrorCount unchanged, relock after 2 legal Gray steps.
REQ-035 The bench SHALL check reset and saturation: 300 violations -> ErrorCount=255; pulse nReset low mid-run -> all outputs 0 and state IDLE.
